// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID-stage decode feeding registered ID/EX, EX/MEM and MEM/WB
// control bundles, with load-use stall, flush, and HLT drain to a sticky halt.
module ctrl_pipe_unit #(
    parameter int WORD_SIZE     = 16,
    parameter int REG_ADDR_W    = 2,
    parameter int LINK_REG      = 2,
    parameter int HAZARD_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_SIZE-1:0]  if_id_inst,
    input  logic                  if_id_valid,
    input  logic                  ext_stall,
    input  logic                  flush_id,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic                  ex_alu_src,
    output logic [3:0]            ex_alu_op,
    output logic [5:0]            ex_func,
    output logic [1:0]            ex_pc_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_link,
    output logic                  ex_reg_write,
    output logic                  ex_is_wwd,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  mem_valid,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic                  mem_link,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  wb_valid,
    output logic                  wb_mem_to_reg,
    output logic                  wb_link,
    output logic                  wb_reg_write,
    output logic                  wb_is_wwd,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  is_halted,
    output logic [WORD_SIZE-1:0]  retired_count
);

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] F_JPR = 6'd25;
    localparam logic [5:0] F_JRL = 6'd26;
    localparam logic [5:0] F_WWD = 6'd28;
    localparam logic [5:0] F_HLT = 6'd29;

    typedef struct packed {
        logic                  valid;
        logic                  alu_src;
        logic [3:0]            alu_op;
        logic [5:0]            func;
        logic [1:0]            pc_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  link;
        logic                  reg_write;
        logic                  is_wwd;
        logic                  is_hlt;
        logic [REG_ADDR_W-1:0] dest;
    } ex_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  link;
        logic                  reg_write;
        logic                  is_wwd;
        logic                  is_hlt;
        logic [REG_ADDR_W-1:0] dest;
    } mem_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_to_reg;
        logic                  link;
        logic                  reg_write;
        logic                  is_wwd;
        logic                  is_hlt;
        logic [REG_ADDR_W-1:0] dest;
    } wb_t;

    ex_t  ex, dec;
    mem_t mem;
    wb_t  wb;

    logic                  halt_pending;
    logic                  use_rs, use_rt;
    logic                  hazard, take;
    logic [3:0]            op;
    logic [5:0]            func;
    logic [REG_ADDR_W-1:0] rs, rt, rd;

    assign op   = if_id_inst[15:12];
    assign func = if_id_inst[5:0];
    assign rs   = if_id_inst[11 -: REG_ADDR_W];
    assign rt   = if_id_inst[9 -: REG_ADDR_W];
    assign rd   = if_id_inst[7 -: REG_ADDR_W];

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        use_rs    = 1'b1;
        use_rt    = 1'b0;
        unique case (op)
            OP_R: begin
                if (func <= 6'd7) begin
                    dec.alu_op    = op;
                    dec.func      = func;
                    dec.reg_write = 1'b1;
                    dec.dest      = rd;
                    use_rt        = 1'b1;
                end else if (func == F_WWD) begin
                    dec.alu_op = op;
                    dec.func   = func;
                    dec.is_wwd = 1'b1;
                end else if (func == F_JPR) begin
                    dec.alu_op = op;
                    dec.func   = func;
                    dec.pc_src = 2'd2;
                end else if (func == F_JRL) begin
                    dec.alu_op    = op;
                    dec.func      = func;
                    dec.pc_src    = 2'd2;
                    dec.link      = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest      = REG_ADDR_W'(LINK_REG);
                end else if (func == F_HLT) begin
                    dec.alu_op = op;
                    dec.func   = func;
                    dec.is_hlt = 1'b1;
                    use_rs     = 1'b0;
                end
            end
            OP_BNE, OP_BEQ: begin
                dec.alu_op = op;
                use_rt     = 1'b1;
            end
            OP_BGZ, OP_BLZ: dec.alu_op = op;
            OP_ADI, OP_ORI, OP_LHI, OP_LWD: begin
                dec.alu_op     = op;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.dest       = rt;
                dec.mem_read   = (op == OP_LWD);
                dec.mem_to_reg = (op == OP_LWD);
            end
            OP_SWD: begin
                dec.alu_op    = op;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                use_rt        = 1'b1;
            end
            OP_JMP: begin
                dec.alu_op = op;
                dec.pc_src = 2'd1;
                use_rs     = 1'b0;
            end
            OP_JAL: begin
                dec.alu_op    = op;
                dec.pc_src    = 2'd1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
                dec.dest      = REG_ADDR_W'(LINK_REG);
                use_rs        = 1'b0;
            end
            default: ;
        endcase
    end

    assign hazard = (HAZARD_DETECT != 0) && ex.valid && ex.mem_read
                    && if_id_valid
                    && ((use_rs && ex.dest == rs) || (use_rt && ex.dest == rt));

    assign stall_out = !flush_id && (halt_pending || hazard || ext_stall);
    assign take      = !flush_id && !halt_pending && !hazard && !ext_stall
                       && if_id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex            <= '0;
            mem           <= '0;
            wb            <= '0;
            halt_pending  <= 1'b0;
            is_halted     <= 1'b0;
            retired_count <= '0;
        end else begin
            ex <= take ? dec : '0;
            if (take && dec.is_hlt)
                halt_pending <= 1'b1;
            mem.valid      <= ex.valid;
            mem.mem_read   <= ex.mem_read;
            mem.mem_write  <= ex.mem_write;
            mem.mem_to_reg <= ex.mem_to_reg;
            mem.link       <= ex.link;
            mem.reg_write  <= ex.reg_write;
            mem.is_wwd     <= ex.is_wwd;
            mem.is_hlt     <= ex.is_hlt;
            mem.dest       <= ex.dest;
            wb.valid       <= mem.valid;
            wb.mem_to_reg  <= mem.mem_to_reg;
            wb.link        <= mem.link;
            wb.reg_write   <= mem.reg_write;
            wb.is_wwd      <= mem.is_wwd;
            wb.is_hlt      <= mem.is_hlt;
            wb.dest        <= mem.dest;
            if (wb.valid && wb.is_hlt)
                is_halted <= 1'b1;
            if (wb.valid)
                retired_count <= retired_count + WORD_SIZE'(1);
        end
    end

    assign ex_valid       = ex.valid;
    assign ex_alu_src     = ex.alu_src;
    assign ex_alu_op      = ex.alu_op;
    assign ex_func        = ex.func;
    assign ex_pc_src      = ex.pc_src;
    assign ex_mem_read    = ex.mem_read;
    assign ex_mem_write   = ex.mem_write;
    assign ex_mem_to_reg  = ex.mem_to_reg;
    assign ex_link        = ex.link;
    assign ex_reg_write   = ex.reg_write;
    assign ex_is_wwd      = ex.is_wwd;
    assign ex_dest        = ex.dest;
    assign mem_valid      = mem.valid;
    assign mem_mem_read   = mem.mem_read;
    assign mem_mem_write  = mem.mem_write;
    assign mem_mem_to_reg = mem.mem_to_reg;
    assign mem_link       = mem.link;
    assign mem_reg_write  = mem.reg_write;
    assign mem_dest       = mem.dest;
    assign wb_valid       = wb.valid;
    assign wb_mem_to_reg  = wb.mem_to_reg;
    assign wb_link        = wb.link;
    assign wb_reg_write   = wb.reg_write;
    assign wb_is_wwd      = wb.is_wwd;
    assign wb_dest        = wb.dest;

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Parameterised successor to the combinational ID-stage decoder. It decodes the 16-bit ISA instruction held in IF/ID and carries the resulting control bundle through registered ID/EX, EX/MEM and MEM/WB stages, each with its own valid bit. It also detects load-use hazards, applies external stall and flush requests, and drains the pipeline on HLT before asserting a sticky `is_halted`. It sits between the IF/ID latch and the datapath's EX/MEM/WB muxes and supplies every stage's control.

## Interface
- `WORD_SIZE`, 16 — instruction width; retire-counter width.
- `REG_ADDR_W`, 2 — register-specifier width; rs=[11:10], rt=[9:8], rd=[7:6] at default.
- `LINK_REG`, 2 — destination register for JAL/JRL.
- `HAZARD_DETECT`, 1 — 1 enables internal load-use stall; 0 leaves only `ext_stall`.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `if_id_inst` in WORD_SIZE — instruction in ID.
- `if_id_valid` in 1 — ID instruction is real (0 = bubble).
- `ext_stall` in 1 — datapath stall request (e.g. memory busy).
- `flush_id` in 1 — kill ID instruction (branch/jump redirect resolved).
- `stall_out` out 1 — hold PC and IF/ID this cycle.
- `ex_valid, ex_alu_src, ex_alu_op[3:0], ex_func[5:0], ex_pc_src[1:0], ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_link, ex_reg_write, ex_is_wwd` out — ID/EX bundle.
- `ex_dest` out REG_ADDR_W — resolved write register.
- `mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_link, mem_reg_write, mem_dest` out — EX/MEM bundle.
- `wb_valid, wb_mem_to_reg, wb_link, wb_reg_write, wb_is_wwd, wb_dest` out — MEM/WB bundle.
- `is_halted` out 1 — HLT has retired; sticky until reset.
- `retired_count` out WORD_SIZE — valid instructions reaching WB.

## Operation
- Decode (combinational, ID):
  - opcode=[15:12], func=[5:0].
  - R-type (opcode 15) ADD/SUB/AND/ORR/NOT/TCP/SHL/SHR: alu_src=0, RegDst=rd, reg_write=1.
  - WWD: is_wwd=1, no writes. JPR: pc_src=2. JRL: pc_src=2, link=1, dest=LINK_REG, reg_write=1.
  - ADI/ORI/LHI: alu_src=1, dest=rt, reg_write=1. LWD: additionally mem_read=1, mem_to_reg=1.
  - SWD: alu_src=1, mem_write=1. BNE/BEQ/BGZ/BLZ: pc_src=0. JMP: pc_src=1. JAL: pc_src=1, link=1, dest=LINK_REG, reg_write=1.
- Every field is driven to 0 when unused; no X outputs.
- Undefined opcode/func decodes as valid NOP (all write enables 0).
- rt-use set: R-type, SWD, BNE, BEQ. rs-use set: all except JMP, JAL, HLT.
- Load-use hazard (HAZARD_DETECT=1): `ex_valid & ex_mem_read & if_id_valid` and `ex_dest` equals used rs or used rt.
- Priority per cycle, highest first:
  - reset.
  - `flush_id`: ID/EX <= bubble, stall_out=0.
  - halt_pending: ID/EX <= bubble, stall_out=1.
  - hazard | ext_stall: ID/EX <= bubble, stall_out=1.
  - otherwise ID/EX <= decode, with valid = if_id_valid.
- EX/MEM and MEM/WB always advance; stall bubbles only at ID/EX.
- A bubble has valid=0 and all enables (reg_write, mem_read, mem_write, link, is_wwd) = 0.
- Halt:
  - A valid, unflushed, unstalled HLT entering ID/EX sets halt_pending.
  - When that HLT is in MEM/WB (`wb_valid`), `is_halted`<=1 at the next edge and stays 1.
  - halt_pending holds `stall_out`=1 until reset.
- `retired_count`: +1 each edge with `wb_valid`=1 (HLT included); wraps 2^WORD_SIZE-1 -> 0.

## Timing
- Reset (async, immediate): all valids, enables, pc_src, dest, `stall_out`, `is_halted`, `retired_count`, halt_pending = 0.
- Decode to `ex_*`: 1 cycle. To `mem_*`: 2 cycles. To `wb_*`: 3 cycles.
- `retired_count` increments at the edge after `wb_valid`.
- `stall_out` is combinational from the current ID/EX contents and inputs. A load-use stall lasts exactly 1 cycle, because the LWD advances to MEM.
- `flush_id` together with hazard: flush wins, no stall.
- Reset asserted mid-drain clears halt_pending. Decoding resumes on the first edge after deassertion.

## Test plan
- ADD r3<=r1,r2 then ADI r1, 5 (valid, no hazards) -> `ex_reg_write`=1 with `ex_dest`=3 at cycle 1, then `ex_dest`=1, `ex_alu_src`=1 at cycle 2; `retired_count`=2 after cycle 4.
- LWD r1 then ADD rs=1 -> `stall_out`=1 for exactly 1 cycle; ID/EX holds a bubble (ex_valid=0, ex_reg_write=0); ADD enters EX one cycle later.
- Same sequence with HAZARD_DETECT=0 -> no stall; ADD follows LWD back-to-back.
- JAL then `flush_id` on the next cycle -> JAL `ex_dest`=LINK_REG, `ex_link`=1; the flushed instruction yields ex_valid=0 and `stall_out`=0, even with `ext_stall`=1.
- HLT followed by ADI -> ADI never enters EX; `stall_out` stays 1; `is_halted`=1 three edges after HLT enters ID/EX; assert reset -> `is_halted`=0 immediately.
- Preload 2^16-1 retirements, then retire one more -> `retired_count` wraps to 0.
